// File: rtl/tx_pkg.sv
// Shared serial-line parameters and transmitter state encoding, used by tx and rx.
package tx_pkg;

    localparam int CLOCK_FREQUENCY = 50_000_000;
    localparam int BAUD_RATE       = 110;

    // Bit time in system clocks, truncated toward zero.
    function automatic int bit_time(input int clock_frequency, input int baud_rate);
        return $rtoi(real'(clock_frequency) / real'(baud_rate));
    endfunction

    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BIT_TIME    = bit_time(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int COUNT_WIDTH = count_width(BIT_TIME);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_if.sv
// Character/flag handshake between a host and the serial transmitter.
interface tx_if;

    logic       load;
    logic [0:7] char;
    logic       clear_flag;
    logic       tx;
    logic       flag;
    logic       busy;

    modport master (
        output load, char, clear_flag,
        input  tx, flag, busy
    );

    modport slave (
        input  load, char, clear_flag,
        output tx, flag, busy
    );

endinterface

// File: rtl/tx_baud_counter.sv
// Bit timer: loads N-1, counts down and pulses tick for one clock on terminal count.
module baud_counter
    import tx_pkg::*;
#(
    parameter int BIT_TIME    = tx_pkg::BIT_TIME,
    parameter int COUNT_WIDTH = tx_pkg::COUNT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam logic [COUNT_WIDTH-1:0] RELOAD = COUNT_WIDTH'(BIT_TIME - 1);

    logic [COUNT_WIDTH-1:0] count;

    // Held at zero while disabled so an idle line never produces ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (restart) begin
            count <= RELOAD;
        end else if (!enable) begin
            count <= '0;
        end else if (count == '0) begin
            count <= RELOAD;
        end else begin
            count <= count - COUNT_WIDTH'(1);
        end
    end

    assign tick = enable && (count == '0);

endmodule

// File: rtl/tx.sv
// Serial character transmitter (start bit, 8 data bits LSB first, stop bit).
// Define TX_TWO_STOP_BITS_EN for two stop bits (ASR-33 110-baud framing).
module tx
    import tx_pkg::*;
#(
    parameter int clock_frequency = CLOCK_FREQUENCY,
    parameter int baud_rate       = BAUD_RATE
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    tx_if.slave  bus
);

    localparam int N  = bit_time(clock_frequency, baud_rate);
    localparam int CW = count_width(N);

    tx_state_e  state;
    tx_state_e  state_next;
    logic       sync_clear;
    logic       tick;
    logic       start_frame;
    logic       frame_done;
    logic       stop_last;
    logic [2:0] bit_cnt;
    logic [0:7] shift_reg;
    logic       tx_q;
    logic       flag_q;

    assign sync_clear = reset | clear;

    baud_counter #(
        .BIT_TIME    (N),
        .COUNT_WIDTH (CW)
    ) u_baud (
        .clk     (clk),
        .reset   (sync_clear),
        .restart (start_frame),
        .enable  (state != IDLE),
        .tick    (tick)
    );

`ifdef TX_TWO_STOP_BITS_EN
    logic stop_cnt;

    always_ff @(posedge clk) begin
        if (sync_clear || state != STOP) begin
            stop_cnt <= 1'b0;
        end else if (tick) begin
            stop_cnt <= ~stop_cnt;
        end
    end

    assign stop_last = stop_cnt;
`else
    assign stop_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (sync_clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    state_next  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick && bit_cnt == 3'd7) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (tick && stop_last) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The line is registered; shift_reg[7] always holds the next data bit to go out.
    always_ff @(posedge clk) begin
        if (sync_clear) begin
            tx_q      <= 1'b1;
            flag_q    <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (start_frame) begin
                shift_reg <= bus.char;
                bit_cnt   <= '0;
                tx_q      <= 1'b0;
            end else if (tick) begin
                case (state)
                    START: begin
                        tx_q      <= shift_reg[7];
                        shift_reg <= {1'b0, shift_reg[0:6]};
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
                            tx_q <= 1'b1;
                        end else begin
                            tx_q      <= shift_reg[7];
                            shift_reg <= {1'b0, shift_reg[0:6]};
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // A completing frame outranks a simultaneous clear_flag.
            if (frame_done) begin
                flag_q <= 1'b1;
            end else if (bus.clear_flag) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign bus.tx   = tx_q;
    assign bus.flag = flag_q;
    assign bus.busy = (state != IDLE);

endmodule
